// File: rtl/vend_pkg.sv
// Shared constants for the vending-machine credit block: credit width,
// coin values and the event-priority encoding.
package vend_pkg;

  localparam int unsigned CW  = 4;
  localparam int unsigned W5  = CW + 1;
  localparam int unsigned NEV = 5;

  localparam int unsigned NICKEL = 1;
  localparam int unsigned DIME   = 2;

  localparam int unsigned IDX_NIC  = 0;
  localparam int unsigned IDX_DIM  = 1;
  localparam int unsigned IDX_OBJ2 = 2;
  localparam int unsigned IDX_OBJ1 = 3;
  localparam int unsigned IDX_CH   = 4;

  // Winning event of a cycle; ch > obj1 > obj2 > dim > nic
  typedef enum logic [2:0] {
    EV_NONE,
    EV_NIC,
    EV_DIM,
    EV_OBJ2,
    EV_OBJ1,
    EV_CH
  } ev_t;

endpackage

// File: rtl/vend_if.sv
// Vending-machine user interface: coin/purchase/change request levels in,
// current credit out.
interface vend_if;
  import vend_pkg::*;

  logic          nic;
  logic          dim;
  logic          obj1;
  logic          obj2;
  logic          ch;
  logic [CW-1:0] coin;

  modport master (output nic, dim, obj1, obj2, ch, input coin);
  modport slave  (input nic, dim, obj1, obj2, ch, output coin);

endinterface

// File: rtl/vend_edge.sv
// Rising-edge detector for one request input, with an optional 2-flop
// synchronizer in front (enabled by macro VEND_INPUT_SYNC_EN).
module vend_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic s;
  logic prev;

`ifdef VEND_INPUT_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '1;
    else        sync <= {sync[0], d};
  end

  assign s = sync[1];
`else
  assign s = d;
`endif

  // Previous sample resets high so a level held through reset is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b1;
    else        prev <= s;
  end

  assign rise = s & ~prev;

endmodule

// File: rtl/vend.sv
// Vending-machine credit tracker: one edge detector per input, priority
// resolution of simultaneous events, saturating credit register on coin.
module vend
  import vend_pkg::*;
#(
  parameter int PRICE1     = 3,
  parameter int PRICE2     = 2,
  parameter int MAX_CREDIT = 15
) (
  input  logic   clk,
  input  logic   rst_n,
  vend_if.slave  bus
);

  localparam logic [W5-1:0] P1   = W5'(PRICE1);
  localparam logic [W5-1:0] P2   = W5'(PRICE2);
  localparam logic [W5-1:0] MAXC = W5'(MAX_CREDIT);

  logic [NEV-1:0] lvl;
  logic [NEV-1:0] rise;
  logic [CW-1:0]  credit;
  logic [CW-1:0]  credit_nx;
  logic [W5-1:0]  c5;
  ev_t            ev;

  assign lvl[IDX_NIC]  = bus.nic;
  assign lvl[IDX_DIM]  = bus.dim;
  assign lvl[IDX_OBJ2] = bus.obj2;
  assign lvl[IDX_OBJ1] = bus.obj1;
  assign lvl[IDX_CH]   = bus.ch;

  for (genvar i = 0; i < NEV; i++) begin : g_edge
    vend_edge u_edge (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (lvl[i]),
      .rise (rise[i])
    );
  end

  always_comb begin
    ev = EV_NONE;
    if      (rise[IDX_CH])   ev = EV_CH;
    else if (rise[IDX_OBJ1]) ev = EV_OBJ1;
    else if (rise[IDX_OBJ2]) ev = EV_OBJ2;
    else if (rise[IDX_DIM])  ev = EV_DIM;
    else if (rise[IDX_NIC])  ev = EV_NIC;
  end

  // Widened by one bit so credit+coin cannot wrap before the limit compare
  always_comb begin
    c5        = {1'b0, credit};
    credit_nx = credit;
    unique case (ev)
      EV_CH:   credit_nx = '0;
      EV_OBJ1: if (c5 >= P1) credit_nx = CW'(c5 - P1);
      EV_OBJ2: if (c5 >= P2) credit_nx = CW'(c5 - P2);
      EV_DIM:  if (c5 + W5'(DIME) <= MAXC)   credit_nx = CW'(c5 + W5'(DIME));
      EV_NIC:  if (c5 + W5'(NICKEL) <= MAXC) credit_nx = CW'(c5 + W5'(NICKEL));
      default: credit_nx = credit;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) credit <= '0;
    else        credit <= credit_nx;
  end

  assign bus.coin = credit;

endmodule

// File: tb/tb_vend.sv
// Scoreboard bench for vend: driver applies input levels and queues the
// expected credit per cycle; a negedge monitor pops and compares.
module tb_vend;

  localparam int P1   = 3;
  localparam int P2   = 2;
  localparam int MAXC = 15;
`ifdef VEND_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  // Level vector bit order: {ch, obj1, obj2, dim, nic}
  localparam logic [4:0] NIC  = 5'b00001;
  localparam logic [4:0] DIM  = 5'b00010;
  localparam logic [4:0] OBJ2 = 5'b00100;
  localparam logic [4:0] OBJ1 = 5'b01000;
  localparam logic [4:0] CH   = 5'b10000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  vend_if bus ();

  vend #(.PRICE1(P1), .PRICE2(P2), .MAX_CREDIT(MAXC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    due;
    int    exp;
    string tag;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  int         credit = 0;
  logic [4:0] last = 5'b11111;

  // Reference behaviour: one winning event per cycle, saturating/rejecting
  function automatic int model(input int c, input logic [4:0] r);
    if (r[4]) return 0;
    if (r[3]) return (c >= P1) ? c - P1 : c;
    if (r[2]) return (c >= P2) ? c - P2 : c;
    if (r[1]) return (c + 2 <= MAXC) ? c + 2 : c;
    if (r[0]) return (c + 1 <= MAXC) ? c + 1 : c;
    return c;
  endfunction

  task automatic cycle(input logic [4:0] v, input string tag);
    exp_t e;
    {bus.ch, bus.obj1, bus.obj2, bus.dim, bus.nic} = v;
    credit = model(credit, v & ~last);
    last   = v;
    e.due  = cyc + 1 + LAT;
    e.exp  = credit;
    e.tag  = tag;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic pulse(input logic [4:0] v, input string tag);
    cycle(v, tag);
    cycle(5'b00000, tag);
  endtask

  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.coin !== 4'd0) begin
      fails++;
      $display("FAIL %s: coin=%0d during reset, required 0", tag, bus.coin);
    end
    sb.delete();
    credit = 0;
    last   = 5'b11111;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        tests++;
        if (e.due != cyc || int'(bus.coin) != e.exp) begin
          fails++;
          $display("FAIL %s: coin=%0d required %0d (cycle %0d, due %0d)",
                   e.tag, bus.coin, e.exp, cyc, e.due);
        end
      end
    end
  end

  initial begin
    logic [4:0] v;
    {bus.ch, bus.obj1, bus.obj2, bus.dim, bus.nic} = 5'b00000;
    #1;
    tests++;
    if (bus.coin !== 4'd0) begin
      fails++;
      $display("FAIL reset: coin=%0d required 0", bus.coin);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) pulse(NIC, "three_nickels");
    pulse(OBJ1, "buy_obj1");
    pulse(CH, "change_at_zero");

    pulse(NIC, "nic_dim_obj2");
    pulse(DIM, "nic_dim_obj2");
    pulse(OBJ2, "nic_dim_obj2");
    pulse(CH, "clear");

    for (int i = 0; i < 7; i++) pulse(DIM, "fill_to_14");
    pulse(DIM, "dime_rejected_at_14");
    pulse(NIC, "nickel_to_15");
    pulse(NIC, "nickel_rejected_at_15");
    pulse(CH, "clear");

    pulse(NIC, "credit1");
    pulse(OBJ1, "obj1_insufficient");
    pulse(NIC, "credit2");
    pulse(OBJ1 | OBJ2, "obj1_wins_over_obj2");
    pulse(DIM, "credit4");
    pulse(NIC, "credit5");
    pulse(CH | NIC, "ch_wins_over_nic");

    for (int i = 0; i < 50; i++) cycle(NIC, "nic_held_once");
    do_reset("reset_mid_hold");
    for (int i = 0; i < 5; i++) cycle(NIC, "held_through_reset");
    cycle(5'b00000, "held_through_reset");

    v = 5'b00000;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(3) == 0) v[b] = ~v[b];
      if ($urandom_range(149) == 0) do_reset("random_reset");
      cycle(v, "random");
    end
    cycle(5'b00000, "random");

    repeat (LAT + 3) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d checks left pending, required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vend.md
VEND -- requirements
Module: vend

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk (rising edge) and rst_n.
REQ-002 Parameter PRICE1, default 3: obj1 price in nickel units (5c each).
REQ-003 Parameter PRICE2, default 2: obj2 price in nickel units.
REQ-004 Parameter MAX_CREDIT, default 15: maximum credit in nickel units; must be no more than 15.
REQ-005 Port clk, input, 1: system clock.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port nic, input, 1: nickel inserted (level, held for several cycles).
REQ-008 Port dim, input, 1: dime inserted (level).
REQ-009 Port obj1, input, 1: purchase request for item 1 (level).
REQ-010 Port obj2, input, 1: purchase request for item 2 (level).
REQ-011 Port ch, input, 1: change-return request (level).
REQ-012 Port coin, output, 4: current credit in nickel units, driven directly from a register (Moore output).

Function
REQ-013 Each input SHALL act only on its rising edge, detected as current sample = 1 and previous sample = 0; a held level SHALL NOT cause a repeated action.
REQ-014 The state SHALL be a credit register of 0..MAX_CREDIT, and coin SHALL equal this register.
REQ-015 On a nic edge, credit SHALL increase by 1 if credit+1 <= MAX_CREDIT; otherwise the coin is rejected and credit is unchanged.
REQ-016 On a dim edge, credit SHALL increase by 2 if credit+2 <= MAX_CREDIT; otherwise credit is unchanged.
REQ-017 On an obj1 edge, credit SHALL decrease by PRICE1 if credit >= PRICE1; otherwise credit is unchanged.
REQ-018 On an obj2 edge, credit SHALL decrease by PRICE2 if credit >= PRICE2; otherwise credit is unchanged.
REQ-019 On a ch edge, credit SHALL become 0.
REQ-020 Simultaneous edges in one cycle SHALL resolve by priority ch > obj1 > obj2 > dim > nic. Only the winning event SHALL act; the others are discarded, not queued.
REQ-021 Latency SHALL be: coin updates at the first clk edge on which the detector sees the input at 1 (plus the synchronizer delay when enabled, REQ-025).
REQ-022 Arithmetic SHALL use at least 5-bit intermediates so that the saturation compare cannot wrap.

Reset
REQ-023 On rst_n low, credit/coin SHALL go to 0 immediately and all previous-sample registers SHALL go to 1. As a result, an input held high through reset release causes no action.
REQ-024 Asserting reset mid-operation SHALL abandon any pending edge. Normal operation SHALL resume on the first clk edge after rst_n rises.

Configuration
REQ-025 With macro VEND_INPUT_SYNC_EN defined, each input SHALL pass through a 2-flop synchronizer before edge detection, adding 2 cycles of latency; synchronizer flops reset to 1. Without the macro, inputs SHALL feed the edge detector directly.

Structure
REQ-026 Package vend_pkg SHALL hold the credit width (4), the nickel and dime values (1, 2) and the event-priority encoding constants.
REQ-027 Sub-module vend_edge SHALL contain the optional synchronizer plus the rising-edge detector, instantiated once per input (5 instances). The top level SHALL hold the priority logic and the credit register.

Verification
REQ-028 Three separate nic pulses from reset -> coin goes 1, 2, 3; then an obj1 pulse -> coin 0; then a ch pulse -> coin stays 0.
REQ-029 nic then dim then obj2 (defaults) -> coin 1, 3, 1.
REQ-030 From credit 14, a dim pulse -> coin stays 14; then a nic pulse -> coin 15; then a nic pulse -> coin stays 15.
REQ-031 With credit 1, an obj1 pulse -> coin stays 1. With credit 2, obj1 and obj2 rising in the same cycle -> obj1 wins and fails (2 < 3), obj2 is discarded, coin stays 2. With credit 5, ch and nic rising in the same cycle -> coin 0.
REQ-032 nic held high for 50 cycles -> coin increments exactly once. Reset asserted mid-hold -> coin 0 immediately. rst_n released with nic still high -> no increment.
REQ-033 With VEND_INPUT_SYNC_EN defined, a nic rising edge -> coin changes exactly 2 cycles later than in the build without the macro.
